// File: rtl/sim_run_ctrl_pkg.sv
// Shared state encodings, default parameter values and width helper for the run controller.
package sim_run_ctrl_pkg;

    localparam logic [1:0] ST_HOLD = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;
    localparam logic [1:0] ST_TOUT = 2'd3;

    localparam int unsigned DEF_ADDR_W       = 32;
    localparam int unsigned DEF_RESET_CYCLES = 2;
    localparam int unsigned DEF_IRQ_CHANNELS = 1;
    localparam int unsigned DEF_IRQ_PERIOD   = 1000;
    localparam int unsigned DEF_MAX_CYCLES   = 8192;
    localparam int unsigned DEF_HALT_STABLE  = 16;

    // Bits needed for a counter that must reach n-1 (never less than one bit).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sim_run_ctrl_irq_chan.sv
// One periodic interrupt channel: fires every PERIOD enabled run cycles, holds until acked.
module sim_run_ctrl_irq_chan
    import sim_run_ctrl_pkg::*;
#(
    parameter int unsigned PERIOD = DEF_IRQ_PERIOD
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic en,
    input  logic ack,
    output logic irq
);

    localparam int unsigned CW = cnt_width(PERIOD);

    logic [CW-1:0] cnt_q;
    logic          tc;

    assign tc = run && en && (cnt_q == CW'(PERIOD - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            irq   <= 1'b0;
        end else if (run) begin
            if (!en || tc) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
            // A terminal count wins over a same-cycle ack; a count while pending is dropped.
            if (tc) begin
                irq <= 1'b1;
            end else if (ack) begin
                irq <= 1'b0;
            end
        end else begin
            irq <= 1'b0;
        end
    end

endmodule

// File: rtl/sim_run_ctrl.sv
// Run controller for the mips core: cpu_reset sequencing, periodic interrupts, halt/timeout end.
module sim_run_ctrl
    import sim_run_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W       = DEF_ADDR_W,
    parameter int unsigned RESET_CYCLES = DEF_RESET_CYCLES,
    parameter int unsigned IRQ_CHANNELS = DEF_IRQ_CHANNELS,
    parameter int unsigned IRQ_PERIOD   = DEF_IRQ_PERIOD,
    parameter int unsigned MAX_CYCLES   = DEF_MAX_CYCLES,
    parameter int unsigned HALT_STABLE  = DEF_HALT_STABLE
) (
    input  logic                    clk,
    input  logic                    reset,
    output logic                    cpu_reset,
    input  logic [IRQ_CHANNELS-1:0] irq_en,
    input  logic [IRQ_CHANNELS-1:0] irq_ack,
    output logic [IRQ_CHANNELS-1:0] interrupt,
    input  logic [ADDR_W-1:0]       pc,
    output logic [31:0]             cycle_count,
    output logic                    halted,
    output logic                    timeout,
    output logic                    done
);

    localparam int unsigned HOLD_W = cnt_width(RESET_CYCLES);
    localparam int unsigned STAB_W = cnt_width(HALT_STABLE);

    logic [1:0]        state_q, state_d;
    logic [HOLD_W-1:0] hold_q;
    logic [STAB_W-1:0] stable_q;
    logic [ADDR_W-1:0] pc_q;
    logic              hold_done, stable_full, pc_same, any_irq;
    logic              hit_tout, hit_halt, chan_run;

    always_comb begin
        hold_done   = (hold_q == HOLD_W'(RESET_CYCLES - 1));
        stable_full = (stable_q == STAB_W'(HALT_STABLE - 1));
        pc_same     = (pc == pc_q);
        any_irq     = |interrupt;
        hit_tout    = (cycle_count == 32'(MAX_CYCLES - 1));
        // A core spinning while an interrupt is pending is waiting, not halted.
        hit_halt    = pc_same && !any_irq && stable_full;
        state_d     = state_q;
        case (state_q)
            ST_HOLD: if (hold_done) state_d = ST_RUN;
            ST_RUN: begin
                if (hit_tout) begin
                    state_d = ST_TOUT;
                end else if (hit_halt) begin
                    state_d = ST_HALT;
                end
            end
            default: ;
        endcase
        // Channels stop on the very edge that ends the run so interrupt is 0 in terminal states.
        chan_run = (state_q == ST_RUN) && (state_d == ST_RUN);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_HOLD;
            cpu_reset   <= 1'b1;
            hold_q      <= '0;
            stable_q    <= '0;
            pc_q        <= '0;
            cycle_count <= '0;
            halted      <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc;
            cpu_reset <= (state_d == ST_HOLD);
            if (state_q == ST_HOLD && !hold_done) begin
                hold_q <= hold_q + HOLD_W'(1);
            end
            if (state_q == ST_RUN) begin
                if (cycle_count != '1) begin
                    cycle_count <= cycle_count + 32'd1;
                end
                if (!pc_same || any_irq) begin
                    stable_q <= '0;
                end else if (!stable_full) begin
                    stable_q <= stable_q + STAB_W'(1);
                end
            end
            if (state_d == ST_TOUT) timeout <= 1'b1;
            if (state_d == ST_HALT) halted <= 1'b1;
        end
    end

    assign done = halted | timeout;

    for (genvar i = 0; i < IRQ_CHANNELS; i++) begin : g_chan
        sim_run_ctrl_irq_chan #(
            .PERIOD(IRQ_PERIOD * (i + 1))
        ) u_chan (
            .clk  (clk),
            .reset(reset),
            .run  (chan_run),
            .en   (irq_en[i]),
            .ack  (irq_ack[i]),
            .irq  (interrupt[i])
        );
    end

endmodule
